// File: rtl/parity_lane_stream.sv
// parity_lane_stream: multi-lane parity generator (streaming, valid/ready,
// one-entry output register) and registered parity checker with a
// saturating error-beat counter and a sticky error flag.
// Optional build macro: PARITY_ERR_INJECT_EN adds inj_lanes, which inverts
// the generated parity bit of the selected lanes on an accepted beat.
module parity_lane_stream #(
  parameter int N_LANES = 4,
  parameter int LANE_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            p_type,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [N_LANES*LANE_W-1:0]       s_data,
`ifdef PARITY_ERR_INJECT_EN
  input  logic [N_LANES-1:0]              inj_lanes,
`endif
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [N_LANES*(LANE_W+1)-1:0]   m_data,
  input  logic                            c_valid,
  input  logic [N_LANES*(LANE_W+1)-1:0]   c_data,
  output logic                            o_valid,
  output logic [N_LANES*LANE_W-1:0]       o_data,
  output logic [N_LANES-1:0]              o_err_lanes,
  output logic [CNT_W-1:0]                err_cnt,
  output logic                            err_sticky,
  input  logic                            clr_err
);

  localparam int SW = LANE_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_LANES-1:0]          inj_bits;
  logic [N_LANES-1:0]          gen_parity;
  logic [N_LANES*SW-1:0]       gen_word;
  logic [N_LANES-1:0]          chk_err;
  logic [N_LANES*LANE_W-1:0]   chk_data;
  logic                        accept;
  logic                        error_beat;

`ifdef PARITY_ERR_INJECT_EN
  assign inj_bits = inj_lanes;
`else
  assign inj_bits = '0;
`endif

  // Per-lane parity generation, parity check and data stripping
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign gen_parity[i] = p_type ? (^s_data[i*LANE_W +: LANE_W])
                                  : (~^s_data[i*LANE_W +: LANE_W]);
    assign gen_word[i*SW +: SW] = {gen_parity[i] ^ inj_bits[i],
                                   s_data[i*LANE_W +: LANE_W]};
    assign chk_err[i] = p_type ? (^c_data[i*SW +: SW])
                               : (~^c_data[i*SW +: SW]);
    assign chk_data[i*LANE_W +: LANE_W] = c_data[i*SW +: LANE_W];
  end

  // The register can take a new beat when empty or draining this cycle
  assign s_ready    = !m_valid || m_ready;
  assign accept     = s_valid && s_ready;
  assign error_beat = c_valid && (|chk_err);

  // Generate-path output register; data holds when nothing is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= gen_word;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Check-path result register; payload only loads on a valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_err_lanes <= '0;
    end else begin
      o_valid <= c_valid;
      if (c_valid) begin
        o_data      <= chk_data;
        o_err_lanes <= chk_err;
      end
    end
  end

  // Error accounting; a clear takes effect before a concurrent error beat
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr_err) begin
      err_cnt    <= error_beat ? CNT_W'(1) : '0;
      err_sticky <= error_beat;
    end else if (error_beat) begin
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_lane_stream.sv
// Directed self-checking bench for parity_lane_stream (N_LANES=4, LANE_W=8,
// CNT_W=4 so that counter saturation is reachable in a short run).
module tb_parity_lane_stream;

  logic        clk;
  logic        rst;
  logic        p_type;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  inj_lanes;
  logic        m_valid;
  logic        m_ready;
  logic [35:0] m_data;
  logic        c_valid;
  logic [35:0] c_data;
  logic        o_valid;
  logic [31:0] o_data;
  logic [3:0]  o_err_lanes;
  logic [3:0]  err_cnt;
  logic        err_sticky;
  logic        clr_err;

  int n_checks;
  int n_fails;

  // Hand-computed protected words, lanes packed {p,byte} from lane 3 down to 0
  // 32'h01_03_00_FF: lane ones counts 1,2,0,8
  localparam logic [31:0] DATA_X   = 32'h0103_00FF;
  localparam logic [35:0] X_ODD    = {9'h001, 9'h103, 9'h100, 9'h1FF};
  localparam logic [35:0] X_EVEN   = {9'h101, 9'h003, 9'h000, 9'h0FF};
  localparam logic [35:0] X_LANE2  = {9'h001, 9'h003, 9'h100, 9'h1FF};
  localparam logic [35:0] X_ALLBAD = {9'h101, 9'h003, 9'h000, 9'h0FF};

  parity_lane_stream #(
    .N_LANES(4),
    .LANE_W (8),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_type     (p_type),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
`ifdef PARITY_ERR_INJECT_EN
    .inj_lanes  (inj_lanes),
`endif
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .c_valid    (c_valid),
    .c_data     (c_data),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_err_lanes(o_err_lanes),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky),
    .clr_err    (clr_err)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_m_valid: got %0b want 0", m_valid); end
    n_checks++; if (m_data !== 36'h0) begin n_fails++; $display("[TB] FAIL rst_m_data: got %h want 0", m_data); end
    n_checks++; if (o_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_o_valid: got %0b want 0", o_valid); end
    n_checks++; if (o_data !== 32'h0) begin n_fails++; $display("[TB] FAIL rst_o_data: got %h want 0", o_data); end
    n_checks++; if (o_err_lanes !== 4'h0) begin n_fails++; $display("[TB] FAIL rst_o_err_lanes: got %b want 0000", o_err_lanes); end
    n_checks++; if (err_cnt !== 4'd0) begin n_fails++; $display("[TB] FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_err_sticky: got %0b want 0", err_sticky); end
    n_checks++; if (s_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL rst_s_ready: got %0b want 1", s_ready); end
  endtask

  // Odd beat then even beat back to back; second accept overlaps a transfer
  task automatic test_generate;
    m_ready = 1'b1;
    p_type  = 1'b0;
    s_data  = DATA_X;
    s_valid = 1'b1;
    tick();
    n_checks++; if (m_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL gen_odd_valid: got %0b want 1", m_valid); end
    n_checks++; if (m_data !== X_ODD) begin n_fails++; $display("[TB] FAIL gen_odd_data: got %h want %h", m_data, X_ODD); end
    n_checks++; if (s_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL gen_full_rate_ready: got %0b want 1", s_ready); end
    p_type = 1'b1;
    tick();
    s_valid = 1'b0;
    n_checks++; if (m_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL gen_even_valid: got %0b want 1", m_valid); end
    n_checks++; if (m_data !== X_EVEN) begin n_fails++; $display("[TB] FAIL gen_even_data: got %h want %h", m_data, X_EVEN); end
    tick();
    n_checks++; if (m_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL gen_drain_valid: got %0b want 0", m_valid); end
    n_checks++; if (m_data !== X_EVEN) begin n_fails++; $display("[TB] FAIL gen_data_hold: got %h want %h", m_data, X_EVEN); end
    p_type = 1'b0;
  endtask

  // Four beats with the sink stalled for three cycles after the first
  task automatic test_back_to_back;
    logic [31:0] beats [4];
    logic [35:0] exp_out [4];
    int src_idx;
    int out_idx;
    logic hs;
    beats[0] = 32'h0000_0000; exp_out[0] = {4{9'h100}};
    beats[1] = 32'h0101_0101; exp_out[1] = {4{9'h001}};
    beats[2] = 32'h0303_0303; exp_out[2] = {4{9'h103}};
    beats[3] = 32'h0707_0707; exp_out[3] = {4{9'h007}};
    src_idx = 0;
    out_idx = 0;
    p_type  = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      m_ready = (cyc >= 4);
      s_valid = (src_idx < 4);
      if (src_idx < 4) s_data = beats[src_idx];
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        n_checks++; if (m_data !== exp_out[0]) begin n_fails++; $display("[TB] FAIL bp_stall_data c%0d: got %h want %h", cyc, m_data, exp_out[0]); end
        n_checks++; if (s_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_stall_ready c%0d: got %0b want 0", cyc, s_ready); end
        n_checks++; if (m_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_stall_valid c%0d: got %0b want 1", cyc, m_valid); end
      end
      if (m_valid && m_ready) begin
        if (out_idx >= 4) begin
          n_checks++; n_fails++;
          $display("[TB] FAIL bp_extra_beat c%0d: got %h want none", cyc, m_data);
        end else begin
          n_checks++; if (m_data !== exp_out[out_idx]) begin n_fails++; $display("[TB] FAIL bp_order beat%0d: got %h want %h", out_idx, m_data, exp_out[out_idx]); end
          n_checks++; if (cyc !== 4 + out_idx) begin n_fails++; $display("[TB] FAIL bp_gap beat%0d: got cycle %0d want %0d", out_idx, cyc, 4 + out_idx); end
        end
        out_idx++;
      end
      hs = s_valid && s_ready;
      tick();
      if (hs) src_idx++;
    end
    s_valid = 1'b0;
    n_checks++; if (out_idx !== 4) begin n_fails++; $display("[TB] FAIL bp_beat_count: got %0d want 4", out_idx); end
  endtask

  task automatic test_check;
    p_type  = 1'b0;
    c_valid = 1'b1;
    c_data  = X_LANE2;
    tick();
    c_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL chk_o_valid: got %0b want 1", o_valid); end
    n_checks++; if (o_data !== DATA_X) begin n_fails++; $display("[TB] FAIL chk_o_data: got %h want %h", o_data, DATA_X); end
    n_checks++; if (o_err_lanes !== 4'b0100) begin n_fails++; $display("[TB] FAIL chk_err_lanes: got %b want 0100", o_err_lanes); end
    n_checks++; if (err_cnt !== 4'd1) begin n_fails++; $display("[TB] FAIL chk_err_cnt: got %0d want 1", err_cnt); end
    n_checks++; if (err_sticky !== 1'b1) begin n_fails++; $display("[TB] FAIL chk_err_sticky: got %0b want 1", err_sticky); end
    c_valid = 1'b1;
    c_data  = X_ODD;
    tick();
    n_checks++; if (o_err_lanes !== 4'b0000) begin n_fails++; $display("[TB] FAIL chk_clean_lanes: got %b want 0000", o_err_lanes); end
    n_checks++; if (err_cnt !== 4'd1) begin n_fails++; $display("[TB] FAIL chk_clean_cnt: got %0d want 1", err_cnt); end
    // An even-mode word checked in even mode is clean
    p_type = 1'b1;
    c_data = X_EVEN;
    tick();
    c_valid = 1'b0;
    p_type  = 1'b0;
    n_checks++; if (o_err_lanes !== 4'b0000) begin n_fails++; $display("[TB] FAIL chk_even_lanes: got %b want 0000", o_err_lanes); end
    n_checks++; if (err_cnt !== 4'd1) begin n_fails++; $display("[TB] FAIL chk_even_cnt: got %0d want 1", err_cnt); end
    c_data = 36'h0;
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL chk_idle_valid: got %0b want 0", o_valid); end
    n_checks++; if (o_data !== DATA_X) begin n_fails++; $display("[TB] FAIL chk_idle_hold: got %h want %h", o_data, DATA_X); end
  endtask

  task automatic test_saturation;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++; if (err_cnt !== 4'd0) begin n_fails++; $display("[TB] FAIL clr_alone_cnt: got %0d want 0", err_cnt); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fails++; $display("[TB] FAIL clr_alone_sticky: got %0b want 0", err_sticky); end
    p_type  = 1'b0;
    c_data  = X_ALLBAD;
    c_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) begin
        n_checks++; if (err_cnt !== 4'd3) begin n_fails++; $display("[TB] FAIL sat_count3: got %0d want 3", err_cnt); end
        n_checks++; if (o_err_lanes !== 4'b1111) begin n_fails++; $display("[TB] FAIL sat_all_lanes: got %b want 1111", o_err_lanes); end
      end
      if (i == 15) begin
        n_checks++; if (err_cnt !== 4'd15) begin n_fails++; $display("[TB] FAIL sat_count15: got %0d want 15", err_cnt); end
      end
    end
    n_checks++; if (err_cnt !== 4'd15) begin n_fails++; $display("[TB] FAIL sat_held: got %0d want 15", err_cnt); end
    clr_err = 1'b1;
    tick();
    c_valid = 1'b0;
    n_checks++; if (err_cnt !== 4'd1) begin n_fails++; $display("[TB] FAIL clr_err_cnt: got %0d want 1", err_cnt); end
    n_checks++; if (err_sticky !== 1'b1) begin n_fails++; $display("[TB] FAIL clr_err_sticky: got %0b want 1", err_sticky); end
    tick();
    clr_err = 1'b0;
    n_checks++; if (err_cnt !== 4'd0) begin n_fails++; $display("[TB] FAIL clr_final_cnt: got %0d want 0", err_cnt); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fails++; $display("[TB] FAIL clr_final_sticky: got %0b want 0", err_sticky); end
  endtask

  task automatic test_reset_mid;
    p_type  = 1'b0;
    c_data  = X_LANE2;
    c_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    c_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = DATA_X;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_checks++; if (m_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_held_valid: got %0b want 1", m_valid); end
    n_checks++; if (err_cnt !== 4'd5) begin n_fails++; $display("[TB] FAIL mid_err_cnt: got %0d want 5", err_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_m_valid: got %0b want 0", m_valid); end
    n_checks++; if (m_data !== 36'h0) begin n_fails++; $display("[TB] FAIL mid_m_data: got %h want 0", m_data); end
    n_checks++; if (o_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_o_valid: got %0b want 0", o_valid); end
    n_checks++; if (o_data !== 32'h0) begin n_fails++; $display("[TB] FAIL mid_o_data: got %h want 0", o_data); end
    n_checks++; if (o_err_lanes !== 4'h0) begin n_fails++; $display("[TB] FAIL mid_o_err_lanes: got %b want 0000", o_err_lanes); end
    n_checks++; if (err_cnt !== 4'd0) begin n_fails++; $display("[TB] FAIL mid_err_cnt_rst: got %0d want 0", err_cnt); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_err_sticky: got %0b want 0", err_sticky); end
    n_checks++; if (s_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_s_ready: got %0b want 1", s_ready); end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (m_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_discarded c%0d: got %0b want 0", i, m_valid); end
    end
  endtask

`ifdef PARITY_ERR_INJECT_EN
  task automatic test_inject;
    m_ready   = 1'b1;
    p_type    = 1'b0;
    s_data    = DATA_X;
    inj_lanes = 4'b0100;
    s_valid   = 1'b1;
    tick();
    s_valid   = 1'b0;
    inj_lanes = 4'b0000;
    n_checks++; if (m_data !== X_LANE2) begin n_fails++; $display("[TB] FAIL inj_lane2: got %h want %h", m_data, X_LANE2); end
    tick();
  endtask
`endif

  // Test sequence
  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    p_type    = 1'b0;
    s_valid   = 1'b0;
    s_data    = 32'h0;
    inj_lanes = 4'b0000;
    m_ready   = 1'b0;
    c_valid   = 1'b0;
    c_data    = 36'h0;
    clr_err   = 1'b0;
    test_reset();
    test_generate();
    test_back_to_back();
    test_check();
    test_saturation();
    test_reset_mid();
`ifdef PARITY_ERR_INJECT_EN
    test_inject();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/parity_lane_stream.md
Name: parity_lane_stream

Overview:
- Parametrised successor to the single-word parity generator/checker.
- Handles a multi-lane data word with one parity bit per lane. The generate path is streaming with a valid/ready handshake and a one-entry output register.
- The check path is registered and keeps a saturating error counter and a sticky error flag.
- Sits between the datapath and a link/storage interface: the generate side is used on egress, the check side on ingress.

Parameters:
- N_LANES, 4, number of protected lanes per word (>=1)
- LANE_W, 8, data bits per lane (>=1)
- CNT_W, 16, width of the error-beat counter (>=1)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- p_type  input  1  parity mode for both paths: 0 = odd, 1 = even
- s_valid  input  1  generate-path input beat valid
- s_ready  output  1  generate-path input ready
- s_data  input  N_LANES*LANE_W  raw data; lane i = s_data[i*LANE_W +: LANE_W]
- m_valid  output  1  generate-path output valid
- m_ready  input  1  downstream ready
- m_data  output  N_LANES*(LANE_W+1)  protected word; lane i slice = m_data[i*(LANE_W+1) +: LANE_W+1], parity bit is the MSB of the slice
- c_valid  input  1  check-path input beat valid (no backpressure)
- c_data  input  N_LANES*(LANE_W+1)  protected word, same packing as m_data
- o_valid  output  1  check-path result valid
- o_data  output  N_LANES*LANE_W  stripped data
- o_err_lanes  output  N_LANES  per-lane error for the o_valid beat
- err_cnt  output  CNT_W  count of checked beats with any lane error
- err_sticky  output  1  set on any error, held until cleared
- clr_err  input  1  synchronous clear of err_cnt and err_sticky

Behaviour:
- Parity rule, per lane:
  - odd mode: p = ~^lane, so lane plus parity has an odd number of ones.
  - even mode: p = ^lane.
  - Check error, per lane: odd mode err = ~^{p,lane}; even mode err = ^{p,lane}.
- Reset (rst=1 at an edge): m_valid=0, m_data=0, o_valid=0, o_data=0, o_err_lanes=0, err_cnt=0, err_sticky=0. s_ready=1 in the first cycle after reset.
- Reset has priority over every other input. A beat held in the output register when reset is asserted is discarded, never emitted.
- Generate path:
  - s_ready = !m_valid || m_ready (combinational; gives full throughput).
  - Accept when s_valid && s_ready. The register loads {parity, lane} for all lanes, using the p_type value at the accept edge. m_valid=1 at the next edge. Latency is 1 cycle.
  - Transfer out when m_valid && m_ready. If there is no accept in the same cycle, m_valid clears. Simultaneous transfer and accept reloads the register: m_valid stays 1 and the new beat appears.
  - m_valid && !m_ready: m_data holds stable and s_ready=0. No beat is lost or duplicated.
  - m_data is not forced to zero when m_valid=0; it keeps the last value.
- Check path:
  - Fixed 1-cycle latency. o_valid is c_valid delayed by one cycle.
  - o_data and o_err_lanes load only on c_valid and hold otherwise.
- Error accounting, on a beat where c_valid=1 and the computed error vector is nonzero (an "error beat"):
  - err_cnt increments by 1 and saturates at 2^CNT_W-1.
  - err_sticky is set.
  - Updates happen at the same edge that registers o_err_lanes.
- clr_err:
  - Sets err_cnt=0 and err_sticky=0 at the next edge.
  - If an error beat coincides with clr_err, the result is err_cnt=1 and err_sticky=1: the clear applies first, then the concurrent error is counted.
- Paths are independent and may be active in the same cycle.
- p_type is shared by both paths and is sampled per beat. Changing it mid-stream affects only subsequent beats.

Optional Feature:
- Macro PARITY_ERR_INJECT_EN.
- When defined: adds input port inj_lanes [N_LANES]. On a generate-path accept, lanes with inj_lanes[i]=1 have their parity bit inverted in m_data. inj_lanes is sampled with s_data at the accept edge. The check path is unaffected.
- When undefined: the port does not exist and parity is always correct.

Test Plan (N_LANES=4, LANE_W=8 unless noted):
- Reset: rst=1 for 2 cycles, then 0 -> m_valid=0, m_data=0, o_valid=0, err_cnt=0, err_sticky=0, s_ready=1.
- Generate odd: p_type=0, s_data=32'h01_03_00_FF, m_ready=1 -> next cycle m_valid=1, lane parities [3..0] = 0,1,1,1. Same data with p_type=1 -> parities 1,0,0,0.
- Backpressure: 4 beats A..D with s_valid held; m_ready=0 for 3 cycles after A -> m_data=A stable, s_ready=0. After release, A,B,C,D appear in order with no gaps or repeats.
- Check: loop m_data of 32'h01_03_00_FF (odd) into c_data with lane 2 parity inverted -> one cycle later o_valid=1, o_data=32'h01_03_00_FF, o_err_lanes=4'b0100, err_cnt=1, err_sticky=1. Clean beat -> o_err_lanes=0, err_cnt unchanged.
- Saturation/clear, CNT_W=4: 20 consecutive error beats -> err_cnt=15, held. clr_err plus an error beat in the same cycle -> err_cnt=1, err_sticky=1. clr_err alone -> err_cnt=0, err_sticky=0.
- Reset mid-operation: m_valid=1, m_ready=0, err_cnt=5, assert rst for 1 cycle -> all outputs at reset values. The held beat is never emitted.
